// File: rtl/garland_scheduler.sv
// rtl/garland_scheduler.sv - eight-lamp garland pattern scheduler with debounced mode button
module garland_scheduler #(
    parameter int DIV_W      = 20,
    parameter int STEP_TICKS = 8,
    parameter int DEB_TICKS  = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       BTN_MODE,
    output logic [7:0] LED,
    output logic [1:0] MODE,
    output logic       TICK
);

    typedef enum logic [1:0] {
        SWEEP = 2'd0,
        CHASE = 2'd1,
        BLINK = 2'd2,
        OFF   = 2'd3
    } mode_t;

    localparam logic [7:0] DWELL_LAST = 8'(STEP_TICKS - 1);
    localparam logic [3:0] STAB_LAST  = 4'(DEB_TICKS - 1);

    logic [DIV_W-1:0] presc;
    logic             sync0;
    logic             sync1;
    logic             deb;
    logic             deb_d;
    logic [3:0]       stab;
    logic             mode_req;
    logic             tick_eff;

    mode_t      mode;
    mode_t      mode_next;
    logic [2:0] step;
    logic [2:0] step_next;
    logic [7:0] dwell;
    logic [7:0] dwell_next;

    // Highest step index of each mode; the step counter wraps after it.
    function automatic logic [2:0] last_step(input mode_t m);
        case (m)
            SWEEP:   last_step = 3'd5;
            CHASE:   last_step = 3'd7;
            BLINK:   last_step = 3'd1;
            default: last_step = 3'd0;
        endcase
    endfunction

    // Lamp image for a given mode and step.
    function automatic logic [7:0] pattern(input mode_t m, input logic [2:0] s);
        logic [7:0] p;
        p = 8'h00;
        case (m)
            SWEEP: begin
                case (s)
                    3'd0:    p = 8'h18;
                    3'd1:    p = 8'h24;
                    3'd2:    p = 8'h42;
                    3'd3:    p = 8'h81;
                    3'd4:    p = 8'h00;
                    3'd5:    p = 8'hFF;
                    default: p = 8'h18;
                endcase
            end
            CHASE:   p = 8'h01 << s;
            BLINK:   p = s[0] ? 8'h00 : 8'hFF;
            default: p = 8'h00;
        endcase
        return p;
    endfunction

    assign TICK     = &presc;
    assign mode_req = deb & ~deb_d;
    // A mode change swallows a coincident tick so it counts neither for dwell nor debounce.
    assign tick_eff = TICK & ~mode_req;
    assign MODE     = mode;

    // Free-running prescaler.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc <= '0;
        end else begin
            presc <= presc + DIV_W'(1);
        end
    end

    // Button synchronizer, tick-sampled debouncer and rising-edge history.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
            deb   <= 1'b0;
            deb_d <= 1'b0;
            stab  <= 4'd0;
        end else begin
            sync0 <= BTN_MODE;
            sync1 <= sync0;
            deb_d <= deb;
            if (tick_eff) begin
                if (sync1 != deb) begin
                    if (stab == STAB_LAST) begin
                        deb  <= sync1;
                        stab <= 4'd0;
                    end else begin
                        stab <= stab + 4'd1;
                    end
                end else begin
                    stab <= 4'd0;
                end
            end
        end
    end

    // Mode state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            mode <= SWEEP;
        end else begin
            mode <= mode_next;
        end
    end

    // Next mode, step and dwell: a button press restarts the new mode, otherwise ticks pace the steps.
    always_comb begin
        mode_next  = mode;
        step_next  = step;
        dwell_next = dwell;
        if (mode_req) begin
            case (mode)
                SWEEP:   mode_next = CHASE;
                CHASE:   mode_next = BLINK;
                BLINK:   mode_next = OFF;
                default: mode_next = SWEEP;
            endcase
            step_next  = 3'd0;
            dwell_next = 8'd0;
        end else if (tick_eff) begin
            if (dwell == DWELL_LAST) begin
                dwell_next = 8'd0;
                step_next  = (step == last_step(mode)) ? 3'd0 : step + 3'd1;
            end else begin
                dwell_next = dwell + 8'd1;
            end
        end
    end

    // Step, dwell and the registered lamp image; LED only moves when mode or step does.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            step  <= 3'd0;
            dwell <= 8'd0;
            LED   <= 8'h18;
        end else begin
            step  <= step_next;
            dwell <= dwell_next;
            LED   <= pattern(mode_next, step_next);
        end
    end

endmodule

// File: tb/tb_garland_scheduler.sv
// tb/tb_garland_scheduler.sv - randomized self-checking bench for garland_scheduler
module tb_garland_scheduler;

    localparam int DIV_W = 2;
    localparam int STEP  = 2;
    localparam int DEB   = 2;
    localparam int PER   = 1 << DIV_W;

    logic       CLK;
    logic       RST;
    logic       BTN_MODE;
    logic [7:0] LED;
    logic [1:0] MODE;
    logic       TICK;

    int n_cmp;
    int n_fail;

    garland_scheduler #(.DIV_W(DIV_W), .STEP_TICKS(STEP), .DEB_TICKS(DEB)) dut (
        .CLK(CLK),
        .RST(RST),
        .BTN_MODE(BTN_MODE),
        .LED(LED),
        .MODE(MODE),
        .TICK(TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: cycles since reset, synchronizer history, debounced level, mode/step/dwell.
    int         m_cyc;
    bit         m_s0, m_s1, m_deb, m_debd;
    int         m_cnt, m_mode, m_step, m_dwell;
    int         steps_in_mode [4] = '{6, 8, 2, 1};
    logic [7:0] sweep_tbl [6] = '{8'h18, 8'h24, 8'h42, 8'h81, 8'h00, 8'hFF};

    task automatic model_reset();
        m_cyc = 0; m_s0 = 0; m_s1 = 0; m_deb = 0; m_debd = 0;
        m_cnt = 0; m_mode = 0; m_step = 0; m_dwell = 0;
    endtask

    function automatic logic [7:0] m_led();
        case (m_mode)
            0:       return sweep_tbl[m_step];
            1:       return 8'(1 << m_step);
            2:       return (m_step == 0) ? 8'hFF : 8'h00;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [10:0] m_vec();
        return {m_led(), 2'(m_mode), ((m_cyc % PER) == PER - 1) ? 1'b1 : 1'b0};
    endfunction

    task automatic model_edge(input logic b, input logic r);
        bit tick, press, old_deb;
        if (r) begin
            model_reset();
        end else begin
            tick    = (m_cyc % PER) == PER - 1;
            press   = m_deb && !m_debd;
            old_deb = m_deb;
            if (tick && !press) begin
                if (m_s1 != m_deb) begin
                    m_cnt++;
                    if (m_cnt == DEB) begin
                        m_deb = m_s1;
                        m_cnt = 0;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
            m_debd = old_deb;
            if (press) begin
                m_mode  = (m_mode + 1) % 4;
                m_step  = 0;
                m_dwell = 0;
            end else if (tick) begin
                m_dwell++;
                if (m_dwell == STEP) begin
                    m_dwell = 0;
                    m_step  = (m_step + 1) % steps_in_mode[m_mode];
                end
            end
            m_s1 = m_s0;
            m_s0 = b;
            m_cyc++;
        end
    endtask

    // One clock: the model follows the edge, then control returns at the falling edge.
    task automatic cyc();
        @(posedge CLK);
        model_edge(BTN_MODE, RST);
        @(negedge CLK);
    endtask

    task automatic drive_btn(input logic lvl, input int n);
        BTN_MODE = lvl;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic test_reset();
        #2;
        n_cmp++;
        if ({LED, MODE, TICK} !== {8'h18, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state got=%h want=%h", {LED, MODE, TICK}, {8'h18, 2'd0, 1'b0});
        end
        cyc();
        cyc();
        RST = 1'b0;
    endtask

    task automatic test_free_run();
        logic [7:0] seq [7] = '{8'h18, 8'h24, 8'h42, 8'h81, 8'h00, 8'hFF, 8'h18};
        for (int i = 1; i <= 48; i++) begin
            cyc();
            n_cmp++;
            if ({LED, MODE, TICK} !== {seq[i / 8], 2'd0, (i % 4) == 3}) begin
                n_fail++;
                $display("FAIL free_run cycle=%0d got=%h want=%h", i, {LED, MODE, TICK},
                         {seq[i / 8], 2'd0, (i % 4) == 3});
            end
        end
    endtask

    task automatic test_mode_presses();
        logic [7:0] led_after [4] = '{8'h01, 8'hFF, 8'h00, 8'h18};
        logic [1:0] mode_after [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
        logic [1:0] prev;
        int changes;
        for (int k = 0; k < 4; k++) begin
            changes = 0;
            for (int i = 0; i < 40; i++) begin
                BTN_MODE = (i < 20);
                prev = MODE;
                cyc();
                n_cmp++;
                if ({LED, MODE, TICK} !== m_vec()) begin
                    n_fail++;
                    $display("FAIL press_model k=%0d i=%0d got=%h want=%h", k, i, {LED, MODE, TICK}, m_vec());
                end
                if (MODE !== prev) begin
                    changes++;
                    n_cmp++;
                    if ({LED, MODE} !== {led_after[k], mode_after[k]}) begin
                        n_fail++;
                        $display("FAIL press_step0 k=%0d got=%h want=%h", k, {LED, MODE}, {led_after[k], mode_after[k]});
                    end
                end
            end
            n_cmp++;
            if (changes != 1) begin
                n_fail++;
                $display("FAIL press_count k=%0d got=%0d want=1", k, changes);
            end
        end
    endtask

    task automatic test_chase_blink();
        logic [7:0] prev;
        int changes, last_at;
        drive_btn(1'b1, 20);
        drive_btn(1'b0, 20);
        changes = 0;
        for (int i = 0; i < 64; i++) begin
            prev = LED;
            cyc();
            n_cmp++;
            if ({LED, MODE, TICK} !== m_vec()) begin
                n_fail++;
                $display("FAIL chase_model i=%0d got=%h want=%h", i, {LED, MODE, TICK}, m_vec());
            end
            if (LED !== prev) begin
                changes++;
                n_cmp++;
                if (LED !== {prev[6:0], prev[7]}) begin
                    n_fail++;
                    $display("FAIL chase_walk got=%h want=%h", LED, {prev[6:0], prev[7]});
                end
            end
        end
        n_cmp++;
        if (changes != 8) begin
            n_fail++;
            $display("FAIL chase_steps got=%0d want=8", changes);
        end
        drive_btn(1'b1, 20);
        drive_btn(1'b0, 20);
        changes = 0;
        last_at = -1;
        for (int i = 0; i < 32; i++) begin
            prev = LED;
            cyc();
            n_cmp++;
            if ({LED, MODE} !== {m_led(), 2'd2}) begin
                n_fail++;
                $display("FAIL blink_model i=%0d got=%h want=%h", i, {LED, MODE}, {m_led(), 2'd2});
            end
            if (LED !== prev) begin
                n_cmp++;
                if (LED !== ~prev || (last_at >= 0 && i - last_at != 8)) begin
                    n_fail++;
                    $display("FAIL blink_toggle got=%h want=%h gap=%0d want_gap=8", LED, ~prev, i - last_at);
                end
                changes++;
                last_at = i;
            end
        end
        n_cmp++;
        if (changes != 4) begin
            n_fail++;
            $display("FAIL blink_steps got=%0d want=4", changes);
        end
    endtask

    task automatic test_glitch();
        logic [1:0] start_mode;
        logic [1:0] prev;
        int changes;
        start_mode = MODE;
        drive_btn(1'b1, 4);
        drive_btn(1'b0, 20);
        n_cmp++;
        if ({LED, MODE} !== {m_led(), start_mode}) begin
            n_fail++;
            $display("FAIL glitch_ignored got=%h want=%h", {LED, MODE}, {m_led(), start_mode});
        end
        changes = 0;
        for (int i = 0; i < 220; i++) begin
            BTN_MODE = (i < 200);
            prev = MODE;
            cyc();
            if (MODE !== prev) changes++;
        end
        n_cmp++;
        if (changes != 1 || MODE !== 2'(start_mode + 2'd1) || LED !== m_led()) begin
            n_fail++;
            $display("FAIL long_press changes=%0d mode=%0d led=%h want changes=1 mode=%0d led=%h",
                     changes, MODE, LED, 2'(start_mode + 2'd1), m_led());
        end
    endtask

    task automatic test_async_reset();
        logic [7:0] seq [2] = '{8'h18, 8'h24};
        int guard;
        while (MODE !== 2'd2 && guard < 5) begin
            drive_btn(1'b1, 20);
            drive_btn(1'b0, 20);
            guard++;
        end
        guard = 0;
        while (!(m_mode == 2 && m_step == 1) && guard < 40) begin
            cyc();
            guard++;
        end
        n_cmp++;
        if (guard >= 40 || {LED, MODE} !== {8'h00, 2'd2}) begin
            n_fail++;
            $display("FAIL reach_blink_step1 got=%h want=%h guard=%0d", {LED, MODE}, {8'h00, 2'd2}, guard);
        end
        #2 RST = 1'b1;
        #1;
        n_cmp++;
        if ({LED, MODE, TICK} !== {8'h18, 2'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL async_reset got=%h want=%h", {LED, MODE, TICK}, {8'h18, 2'd0, 1'b0});
        end
        @(negedge CLK);
        cyc();
        RST = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            n_cmp++;
            if ({LED, MODE} !== {seq[i / 8], 2'd0} || {LED, MODE, TICK} !== m_vec()) begin
                n_fail++;
                $display("FAIL restart cycle=%0d got=%h want=%h", i, {LED, MODE}, {seq[i / 8], 2'd0});
            end
        end
    endtask

    task automatic test_random();
        int run;
        int done;
        done = 0;
        while (done < 1500) begin
            BTN_MODE = $urandom_range(0, 1);
            run = $urandom_range(1, 24);
            for (int i = 0; i < run; i++) begin
                cyc();
                done++;
                n_cmp++;
                if ({LED, MODE, TICK} !== m_vec()) begin
                    n_fail++;
                    $display("FAIL random cycle=%0d got=%h want=%h", done, {LED, MODE, TICK}, m_vec());
                end
            end
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        RST      = 1'b1;
        BTN_MODE = 1'b0;
        model_reset();
        test_reset();
        test_free_run();
        test_mode_presses();
        test_chase_blink();
        test_glitch();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/garland_scheduler.md
GARLAND_SCHEDULER -- requirements
Module: garland_scheduler

Interface
REQ-001 Parameter DIV_W, default 20, prescaler width; one tick every 2^DIV_W CLK cycles.
REQ-002 Parameter STEP_TICKS, default 8, ticks per pattern step, legal range 1..255.
REQ-003 Parameter DEB_TICKS, default 2, consecutive ticks of stable button level required before acceptance, legal range 1..15.
REQ-004 CLK  input  1  single system clock; all state SHALL update on its rising edge.
REQ-005 RST  input  1  reset, asynchronous and active-high.
REQ-006 BTN_MODE  input  1  raw, asynchronous mode push-button, active-high.
REQ-007 LED  output  8  garland drive; bit n drives lamp n; 1 = on.
REQ-008 MODE  output  2  current mode code.
REQ-009 TICK  output  1  one-CLK pulse on each prescaler tick.

Function
REQ-010 Prescaler SHALL be a free-running DIV_W-bit up-counter that wraps from all-ones to 0; TICK SHALL be 1 exactly in the cycle the counter equals all-ones.
REQ-011 BTN_MODE SHALL pass through a two-flop synchronizer before any use.
REQ-012 Debouncer: the debounced level SHALL change only after the synchronized level differs from it on DEB_TICKS consecutive TICK cycles; any reversion before that SHALL clear the stability count.
REQ-013 A 0->1 transition of the debounced level SHALL produce a one-CLK mode_req pulse; holding the button SHALL yield exactly one mode_req per press.
REQ-014 Mode FSM states and codes: SWEEP=0, CHASE=1, BLINK=2, OFF=3; on mode_req, SWEEP->CHASE->BLINK->OFF->SWEEP.
REQ-015 On mode_req the step index and dwell counter SHALL clear to 0, and LED and MODE SHALL show step 0 of the new mode from the next CLK edge.
REQ-016 Dwell counter SHALL increment on each TICK; on the TICK that makes it reach STEP_TICKS it SHALL clear to 0 and the step index SHALL advance, wrapping after the last step of the mode.
REQ-017 SWEEP steps 0..5: 0x18, 0x24, 0x42, 0x81, 0x00, 0xFF, then wrap to step 0.
REQ-018 CHASE steps 0..7: 0x01 shifted left by the step index (0x01, 0x02 ... 0x80), then wrap.
REQ-019 BLINK steps 0..1: 0xFF, 0x00, then wrap.
REQ-020 OFF: single step; LED SHALL stay 0x00; the dwell counter SHALL still run.
REQ-021 LED SHALL be registered; it SHALL change only on a step advance, a mode change, or reset.
REQ-022 mode_req and TICK in the same cycle: mode_req SHALL win; that TICK SHALL NOT count toward dwell or the debouncer stability count.
REQ-023 Step index width SHALL be 3 bits and dwell counter width 8 bits; index values outside the current mode's range SHALL NOT occur.

Reset
REQ-024 RST asserted SHALL immediately, without waiting for CLK, set: prescaler=0, sync flops=0, debounced level=0, stability count=0, mode=SWEEP, step=0, dwell=0, LED=0x18, MODE=0, TICK=0.
REQ-025 Deassertion of RST mid-pattern SHALL resume from the REQ-024 state; no partial mode_req SHALL survive reset.

Verification (DIV_W=2, STEP_TICKS=2, DEB_TICKS=2 unless stated)
REQ-026 Reset then free-run with no button for 48 CLK -> TICK every 4th CLK; LED sequence 0x18, 0x24, 0x42, 0x81, 0x00, 0xFF, 0x18, each value held 8 CLK; MODE=0 throughout.
REQ-027 Press BTN_MODE for 20 CLK, release, repeat 4 times -> MODE steps 1, 2, 3, 0 once per press; LED=0x01, 0xFF, 0x00, 0x18 respectively on the CLK after each mode_req.
REQ-028 In CHASE mode, run 64 CLK -> LED walks 0x01 through 0x80 and wraps to 0x01; in BLINK mode LED alternates 0xFF/0x00 every 8 CLK.
REQ-029 Button glitch high for 1 TICK only, and a held press of 200 CLK -> glitch causes no mode change; held press causes exactly one mode change.
REQ-030 Force mode_req coincident with TICK -> dwell stays 0 and step stays 0 after the edge; next step advance occurs 2 TICKs later.
REQ-031 Assert RST asynchronously between CLK edges while in BLINK at step 1 -> LED=0x18 and MODE=0 before the next CLK edge; after release, sequence restarts at SWEEP step 0.
